// File: rtl/dram_read_pkg.sv
// Shared types and constants for the AXI4 DRAM read master.
// Used by dram_read_master (optional rlast checking under DRAM_READ_RLAST_CHECK_EN).
package dram_read_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // AXI size code: log2 of the bytes per beat.
    function automatic logic [2:0] axi_size(input int data_width);
        int         bytes;
        logic [2:0] size;
        bytes = data_width / 8;
        size  = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((1 << i) == bytes) begin
                size = 3'(i);
            end
        end
        return size;
    endfunction

endpackage

// File: rtl/dram_read_master.sv
// AXI4 single-burst read master: one INCR burst per request, R beats returned registered.
// Define DRAM_READ_RLAST_CHECK_EN to enable the beat-count versus rlast protocol check.
module dram_read_master
    import dram_read_pkg::*;
#(
    parameter int DRAM_ADDR_WIDTH = 39,
    parameter int DRAM_DATA_WIDTH = 128,
    parameter int AXI_ID_WIDTH    = 16,
    parameter int AXI_ID          = 0
) (
    input  logic                       m_axi_aclk,
    input  logic                       m_axi_areset,
    input  logic [DRAM_ADDR_WIDTH-1:0] dram_read_addr,
    input  logic [7:0]                 dram_read_len,
    input  logic                       dram_read_en,
    output logic                       dram_read_busy,
    output logic [DRAM_DATA_WIDTH-1:0] dram_read_data,
    output logic                       dram_read_data_valid,
    input  logic                       dram_read_err_clr,
    output logic                       dram_read_error,
    output logic                       dram_read_drop,
    output logic                       dram_read_proto_err,
    output logic [DRAM_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                 m_axi_arlen,
    output logic [2:0]                 m_axi_arsize,
    output logic [1:0]                 m_axi_arburst,
    output logic [AXI_ID_WIDTH-1:0]    m_axi_arid,
    output logic                       m_axi_arvalid,
    input  logic                       m_axi_arready,
    input  logic [DRAM_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                 m_axi_rresp,
    input  logic                       m_axi_rlast,
    input  logic [AXI_ID_WIDTH-1:0]    m_axi_rid,
    input  logic                       m_axi_rvalid,
    output logic                       m_axi_rready
);

    localparam logic [2:0] ARSIZE = axi_size(DRAM_DATA_WIDTH);

    state_t                       state_q, state_d;
    logic [DRAM_ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic [7:0]                   arlen_q, arlen_d;
    logic                         arvalid_q, arvalid_d;
    logic                         rready_q, rready_d;
    logic                         busy_q, busy_d;
    logic [DRAM_DATA_WIDTH-1:0]   data_q, data_d;
    logic                         data_valid_q, data_valid_d;
    logic                         error_q, error_d;
    logic                         drop_q, drop_d;

    logic ar_hs;
    logic r_hs;

    assign ar_hs = arvalid_q & m_axi_arready;
    assign r_hs  = rready_q & m_axi_rvalid;

    always_comb begin
        state_d      = state_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        data_d       = data_q;
        data_valid_d = r_hs;
        if (r_hs) begin
            data_d = m_axi_rdata;
        end

        case (state_q)
            IDLE: begin
                if (dram_read_en) begin
                    araddr_d = dram_read_addr;
                    arlen_d  = dram_read_len;
                    state_d  = ADDR;
                end
            end
            ADDR: begin
                if (ar_hs) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                // Only rlast ends the burst, even if the beat count disagrees.
                if (r_hs && m_axi_rlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        arvalid_d = (state_d == ADDR);
        rready_d  = (state_d == DATA);
        busy_d    = (state_d != IDLE);

        // Sticky flags: a set event in the clearing cycle takes priority.
        error_d = (error_q & ~dram_read_err_clr) | (r_hs & m_axi_rresp[1]);
        drop_d  = (drop_q & ~dram_read_err_clr) | (dram_read_en & (state_q != IDLE));
    end

    always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
        if (m_axi_areset) begin
            state_q      <= IDLE;
            araddr_q     <= '0;
            arlen_q      <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            busy_q       <= 1'b0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            error_q      <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            busy_q       <= busy_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            error_q      <= error_d;
            drop_q       <= drop_d;
        end
    end

`ifdef DRAM_READ_RLAST_CHECK_EN
    logic [7:0] beat_q, beat_d;
    logic       proto_err_q, proto_err_d;

    // beat_q holds the zero-based index of the beat currently being accepted.
    always_comb begin
        beat_d = beat_q;
        if (ar_hs) begin
            beat_d = '0;
        end else if (r_hs) begin
            beat_d = beat_q + 8'd1;
        end
        proto_err_d = (proto_err_q & ~dram_read_err_clr)
                    | (r_hs & ((beat_q == arlen_q) != m_axi_rlast));
    end

    always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
        if (m_axi_areset) begin
            beat_q      <= '0;
            proto_err_q <= 1'b0;
        end else begin
            beat_q      <= beat_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign dram_read_proto_err = proto_err_q;
`else
    assign dram_read_proto_err = 1'b0;
`endif

    logic unused_ok;
    assign unused_ok = ^{m_axi_rid, m_axi_rresp[0]};

    assign dram_read_busy       = busy_q;
    assign dram_read_data       = data_q;
    assign dram_read_data_valid = data_valid_q;
    assign dram_read_error      = error_q;
    assign dram_read_drop       = drop_q;
    assign m_axi_araddr         = araddr_q;
    assign m_axi_arlen          = arlen_q;
    assign m_axi_arsize         = ARSIZE;
    assign m_axi_arburst        = AXI_BURST_INCR;
    assign m_axi_arid           = AXI_ID_WIDTH'(AXI_ID);
    assign m_axi_arvalid        = arvalid_q;
    assign m_axi_rready         = rready_q;

endmodule
